// File: rtl/nn_pkg.sv
// Shared types for the network output path: activation type, argmax FSM
// encoding and the address-width helper used to size RAM address ports.
package nn_pkg;

  localparam int ACT_W = 8;

  typedef logic signed [ACT_W-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } argmax_state_e;

  // A single-entry RAM still needs a one-bit address port.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_argmax.sv
// Scans the network output RAM after completion and reports the argmax class.
// Optional macro OUTPUT_ARGMAX_THRESH_EN adds a reject flag against a threshold.
module output_argmax
  import nn_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = addr_w(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     trig_r,
  output logic [ADDR_W-1:0]        abus_r,
  input  logic signed [DATA_W-1:0] dbus_r,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ADDR_W-1:0]        res_class,
  output logic signed [DATA_W-1:0] res_value,
  output logic                     busy
`ifdef OUTPUT_ARGMAX_THRESH_EN
  ,
  input  logic signed [DATA_W-1:0] thresh,
  output logic                     res_reject
`endif
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_HOLD = HOLD;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_OUT - 1);

  logic [1:0]               state_q, state_d;
  logic                     start_prev_q, start_prev_d;
  logic                     trig_q, trig_d;
  logic [ADDR_W-1:0]        abus_q, abus_d;
  logic                     cap_vld_q, cap_vld_d;
  logic [ADDR_W-1:0]        cap_idx_q, cap_idx_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic signed [DATA_W-1:0] max_val_q, max_val_d;
  logic [ADDR_W-1:0]        max_idx_q, max_idx_d;
  logic                     res_valid_q, res_valid_d;
  logic                     take;
  logic signed [DATA_W-1:0] final_val;
`ifdef OUTPUT_ARGMAX_THRESH_EN
  logic signed [DATA_W-1:0] thresh_q, thresh_d;
  logic                     reject_q, reject_d;
`endif

  // Read data is registered one cycle before the compare, which is where the
  // extra cycle of latency beyond the N_OUT reads comes from.
  assign take      = cap_vld_q && ((cap_idx_q == '0) || (data_q > max_val_q));
  assign final_val = take ? data_q : max_val_q;

  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    trig_d       = trig_q;
    abus_d       = abus_q;
    cap_vld_d    = trig_q;
    cap_idx_d    = abus_q;
    data_d       = trig_q ? dbus_r : data_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    res_valid_d  = res_valid_q;
`ifdef OUTPUT_ARGMAX_THRESH_EN
    thresh_d     = thresh_q;
    reject_d     = reject_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !start_prev_q) begin
          state_d = ST_SCAN;
          trig_d  = 1'b1;
          abus_d  = '0;
`ifdef OUTPUT_ARGMAX_THRESH_EN
          thresh_d = thresh;
`endif
        end
      end
      ST_SCAN: begin
        if (trig_q) begin
          if (abus_q == LAST_ADDR) begin
            trig_d = 1'b0;
            abus_d = '0;
          end else begin
            abus_d = abus_q + ADDR_W'(1);
          end
        end
        if (take) begin
          max_val_d = data_q;
          max_idx_d = cap_idx_q;
        end
        if (cap_vld_q && (cap_idx_q == LAST_ADDR)) begin
          state_d     = ST_HOLD;
          res_valid_d = 1'b1;
`ifdef OUTPUT_ARGMAX_THRESH_EN
          reject_d = (final_val < thresh_q);
`endif
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
`ifdef OUTPUT_ARGMAX_THRESH_EN
          reject_d = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      trig_q       <= 1'b0;
      abus_q       <= '0;
      cap_vld_q    <= 1'b0;
      cap_idx_q    <= '0;
      data_q       <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      res_valid_q  <= 1'b0;
`ifdef OUTPUT_ARGMAX_THRESH_EN
      thresh_q     <= '0;
      reject_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      trig_q       <= trig_d;
      abus_q       <= abus_d;
      cap_vld_q    <= cap_vld_d;
      cap_idx_q    <= cap_idx_d;
      data_q       <= data_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      res_valid_q  <= res_valid_d;
`ifdef OUTPUT_ARGMAX_THRESH_EN
      thresh_q     <= thresh_d;
      reject_q     <= reject_d;
`endif
    end
  end

  assign trig_r    = trig_q;
  assign abus_r    = abus_q;
  assign res_valid = res_valid_q;
  assign res_class = max_idx_q;
  assign res_value = max_val_q;
  assign busy      = (state_q == ST_SCAN);
`ifdef OUTPUT_ARGMAX_THRESH_EN
  assign res_reject = reject_q;
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: a 4-entry instance and a 1-entry instance,
// each fed by a RAM model that registers read data on the falling edge.
module tb_output_argmax;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, res_ready;
  logic              trig_r, res_valid, busy;
  logic [1:0]        abus_r, res_class;
  logic signed [7:0] dbus_r, res_value;
  logic signed [7:0] ram [4];

  logic              start1, ready1;
  logic              trig1, valid1, busy1;
  logic [0:0]        abus1, class1;
  logic signed [7:0] dbus1, value1;
  logic signed [7:0] ram1;

`ifdef OUTPUT_ARGMAX_THRESH_EN
  logic signed [7:0] thresh, thresh1;
  logic              res_reject, reject1;
`endif

  int vectors = 0;
  int miscompares = 0;

  output_argmax #(.N_OUT(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .trig_r(trig_r), .abus_r(abus_r),
    .dbus_r(dbus_r), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_value(res_value), .busy(busy)
`ifdef OUTPUT_ARGMAX_THRESH_EN
    , .thresh(thresh), .res_reject(res_reject)
`endif
  );

  output_argmax #(.N_OUT(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .trig_r(trig1), .abus_r(abus1),
    .dbus_r(dbus1), .res_valid(valid1), .res_ready(ready1),
    .res_class(class1), .res_value(value1), .busy(busy1)
`ifdef OUTPUT_ARGMAX_THRESH_EN
    , .thresh(thresh1), .res_reject(reject1)
`endif
  );

  always @(negedge clk) begin
    if (trig_r) dbus_r <= ram[abus_r];
    if (trig1)  dbus1  <= ram1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after edge E0.
  task automatic launch;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    tick(); tick();
    vectors++;
    if ({trig_r, abus_r, res_valid, res_class, res_value, busy} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got trig=%0b abus=%0d valid=%0b class=%0d value=%0d busy=%0b, want all 0",
               trig_r, abus_r, res_valid, res_class, res_value, busy);
    end
    rst = 1'b0;
    ram[0] = 8'sd5; ram[1] = 8'sd6; ram[2] = 8'sd7; ram[3] = 8'sd8;
    launch();
    tick(); tick();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    vectors++;
    if ({trig_r, abus_r, res_valid, res_class, res_value, busy} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_midscan: got trig=%0b abus=%0d valid=%0b class=%0d value=%0d busy=%0b, want all 0",
               trig_r, abus_r, res_valid, res_class, res_value, busy);
    end
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (res_valid || busy) seen++;
      end
      vectors++;
      if (seen != 0) begin
        miscompares++;
        $display("FAIL reset_abandon: got %0d cycles with valid/busy after reset, want 0", seen);
      end
    end
    $display("reset: mid-scan reset abandoned scan");
  endtask

  task automatic test_basic;
    int lat;
    int addr_bad = 0;
    ram[0] = 8'sd5; ram[1] = -8'sd3; ram[2] = 8'sd17; ram[3] = 8'sd2;
    res_ready = 1'b1;
    launch();
    vectors++;
    if (trig_r !== 1'b1 || abus_r !== 2'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_e0: got trig=%0b abus=%0d busy=%0b, want 1 0 1", trig_r, abus_r, busy);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (abus_r !== 2'(k) || trig_r !== 1'b1 || busy !== 1'b1) addr_bad++;
    end
    tick();
    if (trig_r !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) addr_bad++;
    vectors++;
    if (addr_bad != 0) begin
      miscompares++;
      $display("FAIL basic_addr_seq: got %0d bad cycles, want 0", addr_bad);
    end
    wait_valid(lat);
    vectors++;
    if (lat + 4 != 5) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d, want 5", lat + 4);
    end
    vectors++;
    if (res_class !== 2'd2 || res_value !== 8'sd17 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got class=%0d value=%0d busy=%0b, want 2 17 0", res_class, res_value, busy);
    end
    tick();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_handshake: got valid=%0b, want 0", res_valid);
    end
    $display("basic: class=%0d value=%0d latency=%0d", res_class, res_value, lat + 4);
  endtask

  task automatic test_tie_negative;
    int lat;
    ram[0] = -8'sd8; ram[1] = -8'sd1; ram[2] = -8'sd1; ram[3] = -8'sd20;
    res_ready = 1'b1;
    launch();
    wait_valid(lat);
    vectors++;
    if (lat != 5 || res_class !== 2'd1 || res_value !== -8'sd1) begin
      miscompares++;
      $display("FAIL tie_negative: got lat=%0d class=%0d value=%0d, want 5 1 -1", lat, res_class, res_value);
    end
    tick();
    $display("tie_negative: class=1 value=-1 checked");
  endtask

  task automatic test_backpressure;
    int lat;
    int unstable = 0;
    ram[0] = 8'sd4; ram[1] = 8'sd100; ram[2] = -8'sd5; ram[3] = 8'sd100;
    res_ready = 1'b0;
    launch();
    wait_valid(lat);
    vectors++;
    if (lat != 5 || res_class !== 2'd1 || res_value !== 8'sd100) begin
      miscompares++;
      $display("FAIL bp_result: got lat=%0d class=%0d value=%0d, want 5 1 100", lat, res_class, res_value);
    end
    for (int i = 0; i < 6; i++) begin
      start = (i % 2 == 1);
      tick();
      if (res_valid !== 1'b1 || res_class !== 2'd1 || res_value !== 8'sd100 ||
          busy !== 1'b0 || trig_r !== 1'b0) unstable++;
    end
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0", unstable);
    end
    start = 1'b1;
    res_ready = 1'b1;
    tick();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: got valid=%0b, want 0", res_valid);
    end
    tick(); tick();
    vectors++;
    if (busy !== 1'b0 || trig_r !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_queue: got busy=%0b trig=%0b, want 0 0", busy, trig_r);
    end
    $display("backpressure: held 6 cycles, start edge during HOLD ignored");
  endtask

  task automatic test_back_to_back;
    int lat;
    ram[0] = 8'sd1; ram[1] = 8'sd2; ram[2] = 8'sd3; ram[3] = 8'sd4;
    res_ready = 1'b1;
    launch();
    wait_valid(lat);
    vectors++;
    if (res_class !== 2'd3 || res_value !== 8'sd4) begin
      miscompares++;
      $display("FAIL b2b_first: got class=%0d value=%0d, want 3 4", res_class, res_value);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    ram[0] = 8'sd127; ram[1] = 8'sd127; ram[2] = -8'sd128; ram[3] = 8'sd0;
    tick();
    vectors++;
    if (busy !== 1'b1 || trig_r !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_restart: got busy=%0b trig=%0b valid=%0b, want 1 1 0", busy, trig_r, res_valid);
    end
    wait_valid(lat);
    vectors++;
    if (lat != 5 || res_class !== 2'd0 || res_value !== 8'sd127) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d class=%0d value=%0d, want 5 0 127", lat, res_class, res_value);
    end
    tick();
    $display("back_to_back: second scan class=0 value=127");
  endtask

  task automatic test_n1;
    int lat = 0;
    ram1 = -8'sd128;
    ready1 = 1'b1;
    start1 = 1'b0;
    tick();
    start1 = 1'b1;
    tick();
    vectors++;
    if (trig1 !== 1'b1 || abus1 !== 1'b0 || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL n1_e0: got trig=%0b abus=%0d busy=%0b, want 1 0 1", trig1, abus1, busy1);
    end
    while (!valid1 && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != 2 || class1 !== 1'b0 || value1 !== -8'sd128) begin
      miscompares++;
      $display("FAIL n1_result: got lat=%0d class=%0d value=%0d, want 2 0 -128", lat, class1, value1);
    end
    tick();
    vectors++;
    if (valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL n1_handshake: got valid=%0b, want 0", valid1);
    end
    start1 = 1'b0;
    $display("n1: class=0 value=-128 latency=%0d", lat);
  endtask

`ifdef OUTPUT_ARGMAX_THRESH_EN
  task automatic test_thresh;
    int lat;
    ram[0] = 8'sd3; ram[1] = 8'sd9; ram[2] = 8'sd1; ram[3] = 8'sd0;
    res_ready = 1'b1;
    thresh = 8'sd10;
    launch();
    thresh = -8'sd100;
    wait_valid(lat);
    vectors++;
    if (res_reject !== 1'b1 || res_value !== 8'sd9) begin
      miscompares++;
      $display("FAIL thresh_10: got reject=%0b value=%0d, want 1 9", res_reject, res_value);
    end
    tick();
    vectors++;
    if (res_reject !== 1'b0) begin
      miscompares++;
      $display("FAIL thresh_clear: got reject=%0b, want 0", res_reject);
    end
    thresh = 8'sd9;
    launch();
    thresh = 8'sd100;
    wait_valid(lat);
    vectors++;
    if (res_reject !== 1'b0 || res_class !== 2'd1) begin
      miscompares++;
      $display("FAIL thresh_9: got reject=%0b class=%0d, want 0 1", res_reject, res_class);
    end
    tick();
    $display("thresh: reject at 10, accept at 9");
  endtask
`endif

  initial begin
    start = 1'b0; start1 = 1'b0; res_ready = 1'b0; ready1 = 1'b0; rst = 1'b1;
    ram1 = '0;
`ifdef OUTPUT_ARGMAX_THRESH_EN
    thresh = '0; thresh1 = '0;
`endif
    test_reset();
    test_basic();
    test_tie_negative();
    test_backpressure();
    test_back_to_back();
    test_n1();
`ifdef OUTPUT_ARGMAX_THRESH_EN
    test_thresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
# output_argmax

Downstream consumer of the neural network's output RAM. Once the network signals completion, this block reads all `N_OUT` signed 8-bit output activations through the RAM read port and finds the index and value of the maximum. It presents the resulting class through a valid/ready handshake to the host or next stage.

## Interface
- `N_OUT`, 4: number of output neurons (≥1)
- `DATA_W`, 8: activation width, signed two's complement
- `ADDR_W`, `$clog2(N_OUT)` (min 1): RAM address width
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  connected to network `ack_network`; a 0→1 transition launches a scan
- `trig_r`  out  1  RAM read enable
- `abus_r`  out  ADDR_W  RAM read address
- `dbus_r`  in  DATA_W signed  RAM read data; RAM registers it on falling edge, so it is valid at the rising edge after the address is issued
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_class`  out  ADDR_W  index of maximum
- `res_value`  out  DATA_W signed  maximum value
- `busy`  out  1  scan in progress

## Operation
- FSM states: IDLE, SCAN, HOLD.
- IDLE: on sampled `start`=1 with registered previous `start`=0, go to SCAN, drive `abus_r`=0, `trig_r`=1. A level held high does not retrigger.
- SCAN: each edge captures `dbus_r` for address k−1 and issues address k. The first word loads max/index unconditionally. Later words replace the current max only if strictly greater (signed compare), so on ties the lowest index wins. After issuing address N_OUT−1, drop `trig_r` on the following edge, consume the last word, then go to HOLD.
- HOLD: `res_valid`=1, `res_class`/`res_value` stable. A cycle with `res_valid`&`res_ready` returns the block to IDLE and clears `res_valid`.
- A `start` edge during SCAN or HOLD is ignored (not queued).
- `rst` at any time: state IDLE, all outputs 0, edge detector previous-value cleared to 0. A scan in progress is abandoned with no result.
- Reset values: `trig_r`=0, `abus_r`=0, `res_valid`=0, `res_class`=0, `res_value`=0, `busy`=0.

## Timing
- Edge E0 samples the `start` rise. `abus_r`=0 and `trig_r`=1 are visible after E0. Address k is issued after edge E0+k.
- `res_valid` rises after edge E0+N_OUT+1. Latency is N_OUT+1 cycles.
- `busy`=1 from after E0 until `res_valid` rises.
- `res_ready` may already be high when `res_valid` rises. The handshake then completes on the next edge, and the earliest next scan can start on the edge after that.
- N_OUT=1: a single read; `res_valid` rises after E0+2.

## Configuration
- `OUTPUT_ARGMAX_THRESH_EN` defined: adds input `thresh` (DATA_W signed) and output `res_reject` (1). `res_reject`=1 when `res_value` < `thresh` (signed). `thresh` is sampled at E0 and held for the scan. `res_reject` is valid with `res_valid` and resets to 0.
- Macro undefined: neither port exists, and behaviour is otherwise identical.

## Structure
- Shared package `nn_pkg`: `act_t` (signed DATA_W), `argmax_state_e` {IDLE, SCAN, HOLD}, and an `ADDR_W` helper function.
- Single module. No sub-module is needed; the compare/update is an inline always block.

## Test plan
- Reset: assert `rst` for 2 cycles mid-SCAN → all outputs 0, state IDLE, no `res_valid` afterwards.
- Basic: RAM {5, −3, 17, 2}, `start` rise, `res_ready`=1 → `res_valid` after 5 cycles, class=2, value=17.
- All negative with tie: {−8, −1, −1, −20} → class=1, value=−1 (lowest index, signed compare).
- Backpressure: `res_ready`=0 for 6 cycles → result held stable. A `start` toggle during HOLD is ignored. Ready → `res_valid` falls next edge.
- N_OUT=1, RAM {−128} → class=0, value=−128, latency 2.
- `OUTPUT_ARGMAX_THRESH_EN`, `thresh`=10: RAM {3, 9, 1, 0} → `res_reject`=1. With `thresh`=9 → `res_reject`=0.
